// File: rtl/ufm_page_fetch_pkg.sv
// Shared constants for the UFM page fetcher: EFB CFG register offsets, opcodes,
// FSM state encoding and the command ROM that walks one fetch sequence.
package ufm_page_fetch_pkg;

  localparam logic [1:0] OFF_CR   = 2'd0;
  localparam logic [1:0] OFF_TXDR = 2'd1;
  localparam logic [1:0] OFF_SR   = 2'd2;
  localparam logic [1:0] OFF_RXDR = 2'd3;

  localparam logic [7:0] OP_ENABLE  = 8'h74;
  localparam logic [7:0] OP_SETADR  = 8'hB4;
  localparam logic [7:0] OP_READ    = 8'hCA;
  localparam logic [7:0] OP_DISABLE = 8'h26;
  localparam logic [7:0] OP_BYPASS  = 8'hFF;
  localparam logic [7:0] CR_OPEN    = 8'h80;
  localparam logic [7:0] CR_CLOSE   = 8'h00;

  localparam int PAGE_BYTES = 16;

  // ROM landmarks: page loop restart, end of READ command, close after RXDR reads, tail, last.
  localparam logic [5:0] IDX_PAGE       = 6'd7;
  localparam logic [5:0] IDX_RD_CMD_END = 6'd21;
  localparam logic [5:0] IDX_RD_CLOSE   = 6'd22;
  localparam logic [5:0] IDX_TAIL       = 6'd23;
  localparam logic [5:0] IDX_LAST       = 6'd33;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_RD, S_WAIT_STB, S_NEXT, S_DONE} state_e;
  typedef enum logic [1:0] {D_CONST, D_ADDR_HI, D_ADDR_LO} dsel_e;

  typedef struct packed {
    logic [1:0] off;
    dsel_e      sel;
    logic [7:0] data;
  } cmd_t;

  function automatic cmd_t cmd_rom(input logic [5:0] idx);
    cmd_t c;
    c.off  = OFF_TXDR;
    c.sel  = D_CONST;
    c.data = 8'h00;
    case (idx)
      6'd0, 6'd6, 6'd16, 6'd22, 6'd27, 6'd33: c.off = OFF_CR;
      6'd1, 6'd7, 6'd17, 6'd23, 6'd28: begin c.off = OFF_CR; c.data = CR_OPEN; end
      6'd2:  c.data = OP_ENABLE;
      6'd3:  c.data = 8'h08;
      6'd8:  c.data = OP_SETADR;
      6'd12: c.data = 8'h40;
      6'd14: c.sel  = D_ADDR_HI;
      6'd15: c.sel  = D_ADDR_LO;
      6'd18: c.data = OP_READ;
      6'd19: c.data = 8'h10;
      6'd21: c.data = 8'h01;
      6'd24: c.data = OP_DISABLE;
      6'd29, 6'd30, 6'd31, 6'd32: c.data = OP_BYPASS;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ufm_page_fetch_if.sv
// Wishbone master port to the EFB plus the byte-sequence port toward page_buffer.
interface ufm_page_fetch_if;
  logic       wb_cyc_o;
  logic       wb_stb_o;
  logic       wb_we_o;
  logic [7:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i;
  logic       wb_ack_i;
  logic       seq_stb;
  logic [7:0] data_seq;
  logic       seq_valid;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, data_seq, seq_valid,
    input  wb_dat_i, wb_ack_i, seq_stb
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, data_seq, seq_valid,
    output wb_dat_i, wb_ack_i, seq_stb
  );
endinterface

// File: rtl/ufm_page_fetch_efb_wb_xfer.sv
// Single classic Wishbone transfer engine. Launches on req while idle, ends on
// ack or after WB_TIMEOUT cycles without one; cyc is always low >=1 cycle between transfers.
module efb_wb_xfer #(
  parameter int WB_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       we,
  input  logic [7:0] adr,
  input  logic [7:0] wdat,
  output logic       ack,
  output logic [7:0] rdat,
  output logic       timeout,
  output logic       wb_cyc,
  output logic       wb_we,
  output logic [7:0] wb_adr,
  output logic [7:0] wb_wdat,
  input  logic [7:0] wb_rdat,
  input  logic       wb_ack
);
  logic [7:0] cnt;

  assign ack     = wb_cyc & wb_ack;
  assign rdat    = wb_rdat;
  assign timeout = wb_cyc & ~wb_ack & (cnt == 8'(WB_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_cyc  <= 1'b0;
      wb_we   <= 1'b0;
      wb_adr  <= 8'h00;
      wb_wdat <= 8'h00;
      cnt     <= 8'h00;
    end else if (wb_cyc) begin
      cnt <= cnt + 8'd1;
      if (wb_ack || timeout) wb_cyc <= 1'b0;
    end else if (req) begin
      wb_cyc  <= 1'b1;
      wb_we   <= we;
      wb_adr  <= adr;
      wb_wdat <= wdat;
      cnt     <= 8'h00;
    end
  end
endmodule

// File: rtl/ufm_page_fetch.sv
// Streams page_count consecutive 16-byte UFM pages out of the MachXO2 EFB CFG port
// into page_buffer, one byte per seq_stb.
module ufm_page_fetch
  import ufm_page_fetch_pkg::*;
#(
  parameter int         PAGE_ADDR_W = 14,
  parameter logic [7:0] CFG_BASE    = 8'h70,
  parameter int         WB_TIMEOUT  = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [PAGE_ADDR_W-1:0] page_addr,
  input  logic [7:0]             page_count,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  ufm_page_fetch_if.master       bus
);
  state_e                 state, state_nxt;
  logic [5:0]             idx;
  logic [3:0]             byte_cnt;
  logic [7:0]             page_cnt;
  logic [PAGE_ADDR_W-1:0] addr;
  logic [13:0]            addr14;
  logic [7:0]             data_q;
  logic                   valid_q, err_q;
  cmd_t                   cmd;
  logic                   req, we, x_ack, x_to;
  logic [7:0]             adr, wdat, x_rdat;

  assign cmd           = cmd_rom(idx);
  assign addr14        = 14'(addr);
  assign err           = err_q;
  assign bus.data_seq  = data_q;
  assign bus.seq_valid = valid_q;
  assign bus.wb_stb_o  = bus.wb_cyc_o;

  efb_wb_xfer #(.WB_TIMEOUT(WB_TIMEOUT)) u_xfer (
    .clk(clk), .rst(rst), .req(req), .we(we), .adr(adr), .wdat(wdat),
    .ack(x_ack), .rdat(x_rdat), .timeout(x_to),
    .wb_cyc(bus.wb_cyc_o), .wb_we(bus.wb_we_o), .wb_adr(bus.wb_adr_o),
    .wb_wdat(bus.wb_dat_o), .wb_rdat(bus.wb_dat_i), .wb_ack(bus.wb_ack_i)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_CMD;
      S_CMD: begin
        if (x_to) state_nxt = S_IDLE;
        else if (x_ack) begin
          if (idx == IDX_RD_CMD_END)    state_nxt = S_WAIT_STB;
          else if (idx == IDX_RD_CLOSE) state_nxt = S_NEXT;
          else if (idx == IDX_LAST)     state_nxt = S_DONE;
        end
      end
      // Skip the cycle seq_valid is high so one strobe level is not consumed twice.
      S_WAIT_STB: if (bus.seq_stb && !valid_q) state_nxt = S_RD;
      S_RD: begin
        if (x_to) state_nxt = S_IDLE;
        else if (x_ack) state_nxt = (byte_cnt == 4'(PAGE_BYTES - 1)) ? S_CMD : S_WAIT_STB;
      end
      S_NEXT:  state_nxt = S_CMD;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req  = 1'b0;
    we   = 1'b0;
    adr  = CFG_BASE + {6'b0, OFF_RXDR};
    wdat = cmd.data;
    busy = (state != S_IDLE) && (state != S_DONE);
    done = (state == S_DONE);
    case (state)
      S_CMD: begin
        req = 1'b1;
        we  = 1'b1;
        adr = CFG_BASE + {6'b0, cmd.off};
      end
      S_RD:    req = 1'b1;
      default: ;
    endcase
    case (cmd.sel)
      D_ADDR_HI: wdat = {2'b00, addr14[13:8]};
      D_ADDR_LO: wdat = addr14[7:0];
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= 6'd0;
      byte_cnt <= 4'd0;
      page_cnt <= 8'd0;
      addr     <= '0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (x_to) err_q <= 1'b1;
      case (state)
        S_IDLE: if (start) begin
          idx      <= 6'd0;
          byte_cnt <= 4'd0;
          addr     <= page_addr;
          page_cnt <= (page_count == 8'd0) ? 8'd1 : page_count;
          err_q    <= 1'b0;
        end
        S_CMD: if (x_ack) idx <= idx + 6'd1;
        S_RD: if (x_ack) begin
          data_q   <= x_rdat;
          valid_q  <= 1'b1;
          byte_cnt <= byte_cnt + 4'd1;
        end
        S_NEXT: begin
          page_cnt <= page_cnt - 8'd1;
          if (page_cnt == 8'd1) idx <= IDX_TAIL;
          else begin
            idx  <= IDX_PAGE;
            addr <= addr + PAGE_ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ufm_page_fetch.sv
// EFB behavioural model + page_buffer byte sink around ufm_page_fetch, directed scenarios.
module tb_ufm_page_fetch;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [13:0] page_addr = '0;
  logic [7:0]  page_count = '0;
  logic        busy, done, err;

  ufm_page_fetch_if bus();

  ufm_page_fetch dut (
    .clk(clk), .rst(rst), .start(start), .page_addr(page_addr), .page_count(page_count),
    .busy(busy), .done(done), .err(err), .bus(bus)
  );

  always #5 clk = ~clk;

  logic        stb = 1'b1, hold3 = 1'b0, clr = 1'b0;
  logic [7:0]  rd_idx = '0, op = '0, last = '0, prev = '0;
  logic        open = 1'b0;
  int          nb = 0, rd_total = 0, done_cnt = 0, run = 0, max_run = 0;
  logic [15:0] wlog[$];
  logic [7:0]  ops[$], setlo[$], sethi[$], rx_q[$];
  int          tests = 0, fails = 0;

  assign bus.wb_dat_i = rd_idx ^ 8'h0F;
  assign bus.seq_stb  = stb;

  // EFB model: ack in the 2nd cycle of cyc; optionally never acks the 3rd RXDR read.
  always @(posedge clk) begin
    if (rst) bus.wb_ack_i <= 1'b0;
    else bus.wb_ack_i <= bus.wb_cyc_o & ~bus.wb_ack_i
                         & ~(hold3 && bus.wb_adr_o == 8'h73 && rd_idx == 8'd2);
    run <= bus.wb_cyc_o ? run + 1 : 0;
    if (done) done_cnt <= done_cnt + 1;
    if (clr) begin
      wlog.delete(); ops.delete(); setlo.delete(); sethi.delete(); rx_q.delete();
      rd_idx <= '0; open <= 1'b0; max_run <= 0;
    end else begin
      if (bus.wb_cyc_o && run + 1 > max_run) max_run <= run + 1;
      if (bus.seq_valid) rx_q.push_back(bus.data_seq);
      if (bus.wb_cyc_o && bus.wb_ack_i) begin
        if (bus.wb_we_o) begin
          wlog.push_back({bus.wb_adr_o, bus.wb_dat_o});
          if (bus.wb_adr_o == 8'h70) begin
            if (bus.wb_dat_o == 8'h80) begin open <= 1'b1; nb <= 0; end
            else begin
              if (open) begin
                ops.push_back(op);
                if (op == 8'hB4) begin setlo.push_back(last); sethi.push_back(prev); end
              end
              open <= 1'b0;
            end
          end else if (bus.wb_adr_o == 8'h71 && open) begin
            if (nb == 0) op <= bus.wb_dat_o;
            prev <= last; last <= bus.wb_dat_o; nb <= nb + 1;
          end
        end else if (bus.wb_adr_o == 8'h73) begin
          rd_idx <= rd_idx + 8'd1; rd_total <= rd_total + 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [13:0] a, input logic [7:0] c);
    @(negedge clk);
    page_addr = a; page_count = c; clr = 1'b1; start = 1'b1;
    @(negedge clk);
    clr = 1'b0; start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output int dn);
    int n = 0;
    int base = done_cnt;
    while (done_cnt == base && err !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    check("end_in_budget", 32'(n < budget), 32'd1);
    repeat (3) @(negedge clk);
    dn = done_cnt - base;
  endtask

  task automatic wait_rx(input int n);
    int k = 0;
    while (rx_q.size() < n && k < 2000) begin @(negedge clk); k++; end
    check("rx_reached", 32'(rx_q.size() >= n), 32'd1);
  endtask

  task automatic check_bytes(input int n);
    logic [7:0] e;
    check("rx_count", 32'(rx_q.size()), 32'(n));
    for (int k = 0; k < n && k < rx_q.size(); k++) begin
      e = 8'(k) ^ 8'h0F;
      check("rx_byte", 32'(rx_q[k]), 32'(e));
    end
  endtask

  initial begin
    int dn, r0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_cyc", 32'(bus.wb_cyc_o), 0);
    check("rst_valid", 32'(bus.seq_valid), 0);
    check("rst_data", 32'(bus.data_seq), 0);
    rst = 1'b0;

    // 1: single page, bytes 0F..00
    launch(14'd0, 8'd1);
    check("t1_busy_hi", 32'(busy), 1);
    wait_end(3000, dn);
    check("t1_done_once", 32'(dn), 1);
    check("t1_busy_lo", 32'(busy), 0);
    check("t1_err", 32'(err), 0);
    check_bytes(16);
    check("t1_ops_n", 32'(ops.size()), 5);

    // 2: four pages from 3
    launch(14'd3, 8'd4);
    wait_end(5000, dn);
    check("t2_done", 32'(dn), 1);
    check_bytes(64);
    check("t2_setadr_n", 32'(setlo.size()), 4);
    for (int i = 0; i < 4 && i < setlo.size(); i++) check("t2_setadr_lo", 32'(setlo[i]), 32'(3 + i));
    check("t2_ops_n", 32'(ops.size()), 11);
    if (ops.size() == 11) begin
      check("t2_disable", 32'(ops[9]), 32'h26);
      check("t2_bypass", 32'(ops[10]), 32'hFF);
    end

    // 3: stall seq_stb low for 200 cycles after byte 5
    launch(14'd9, 8'd1);
    wait_rx(5);
    stb = 1'b0;
    r0 = rd_total;
    repeat (200) @(negedge clk);
    check("t3_no_read", 32'(rd_total - r0), 0);
    check("t3_no_valid", 32'(rx_q.size()), 5);
    check("t3_cyc_idle", 32'(bus.wb_cyc_o), 0);
    check("t3_busy", 32'(busy), 1);
    stb = 1'b1;
    wait_end(3000, dn);
    check("t3_done", 32'(dn), 1);
    check_bytes(16);

    // 4: 3rd RXDR read never acked
    hold3 = 1'b1;
    launch(14'd0, 8'd1);
    wait_end(3000, dn);
    check("t4_no_done", 32'(dn), 0);
    check("t4_err", 32'(err), 1);
    check("t4_busy", 32'(busy), 0);
    check("t4_cyc", 32'(bus.wb_cyc_o), 0);
    check("t4_cyc_len", 32'(max_run), 255);
    check("t4_bytes", 32'(rx_q.size()), 2);
    hold3 = 1'b0;
    launch(14'd0, 8'd1);
    check("t4_err_clr", 32'(err), 0);
    wait_end(3000, dn);
    check("t4_redo_done", 32'(dn), 1);
    check_bytes(16);

    // 5: reset mid-page, then restart
    launch(14'd0, 8'd1);
    wait_rx(8);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_cyc", 32'(bus.wb_cyc_o), 0);
    check("t5_rst_busy", 32'(busy), 0);
    rst = 1'b0;
    launch(14'd0, 8'd1);
    wait_end(3000, dn);
    check("t5_done", 32'(dn), 1);
    check("t5_wlog_n", 32'(wlog.size() >= 3), 1);
    if (wlog.size() >= 3) begin
      check("t5_close0", 32'(wlog[0]), 32'h7000);
      check("t5_open", 32'(wlog[1]), 32'h7080);
      check("t5_enable", 32'(wlog[2]), 32'h7174);
    end
    check_bytes(16);

    // 6: start while busy ignored; address wraps 3FFF -> 0
    launch(14'h3FFF, 8'd2);
    repeat (5) @(negedge clk);
    page_addr = 14'd5; page_count = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end(5000, dn);
    check("t6_done", 32'(dn), 1);
    check("t6_bytes", 32'(rx_q.size()), 32);
    check("t6_setadr_n", 32'(setlo.size()), 2);
    if (setlo.size() == 2) begin
      check("t6_lo0", 32'(setlo[0]), 32'hFF);
      check("t6_hi0", 32'(sethi[0]), 32'h3F);
      check("t6_lo1", 32'(setlo[1]), 32'h00);
      check("t6_hi1", 32'(sethi[1]), 32'h00);
    end

    // page_count=0 behaves as 1
    launch(14'd1, 8'd0);
    wait_end(3000, dn);
    check("t7_done", 32'(dn), 1);
    check_bytes(16);
    check("t7_setadr_n", 32'(setlo.size()), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
